// File: rtl/power_manager_pkg.sv
`default_nettype none
// ============================================================================
// Module      : power_manager_pkg
// Description : Shared state codes, setting/mode codes and default thresholds
//               for the power_manager control stage and its dwell timer.
// Revision    : 1.0 - initial release
// ============================================================================
package power_manager_pkg;

    // Controller state codes (3-bit, visible on the debug state port)
    localparam logic [2:0] c_ST_OFF      = 3'd0;
    localparam logic [2:0] c_ST_IDLE     = 3'd1;
    localparam logic [2:0] c_ST_ACTIVE   = 3'd2;
    localparam logic [2:0] c_ST_THROTTLE = 3'd3;
    localparam logic [2:0] c_ST_CHARGE   = 3'd4;
    localparam logic [2:0] c_ST_DEPLETED = 3'd5;

    // Setting codes driven to Power (same encoding as the demand input)
    localparam logic [1:0] c_SET_OFF      = 2'd0;
    localparam logic [1:0] c_SET_LOW      = 2'd1;
    localparam logic [1:0] c_SET_MODERATE = 2'd2;
    localparam logic [1:0] c_SET_HIGH     = 2'd3;

    // Mode codes driven to Power
    localparam logic c_MODE_RECHARGE = 1'b0;
    localparam logic c_MODE_USE      = 1'b1;

    // Default thresholds; the warn level is the point at which Power
    // raises its own warn flag and is kept here for reference.
    localparam logic [7:0] c_FULL_LEVEL   = 8'd179;
    localparam logic [7:0] c_RESUME_LEVEL = 8'd90;
    localparam logic [7:0] c_WARN_LEVEL   = 8'd45;
    localparam int         c_DWELL_CYCLES = 4;

    // States that enforce a minimum residency before a voluntary exit
    function automatic logic isDwellState(input logic [2:0] s);
        return (s == c_ST_ACTIVE) || (s == c_ST_CHARGE);
    endfunction

endpackage
`default_nettype wire

// File: rtl/power_manager_dwell_timer.sv
`default_nettype none
// ============================================================================
// Module      : dwell_timer
// Description : 8-bit loadable down-counter that saturates at zero and flags
//               expiry when the count reaches zero.
// Ports       : clk         - clock, rising edge
//               rst         - asynchronous active-low reset
//               i_load      - load i_loadValue (wins over i_clear)
//               i_loadValue - value loaded on i_load
//               i_clear     - force the count to zero
//               o_expired   - high while the count is zero
// Revision    : 1.0 - initial release
// ============================================================================
module dwell_timer (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_load,
    input  logic [7:0] i_loadValue,
    input  logic       i_clear,
    output logic       o_expired
);

    logic [7:0] r_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= 8'd0;
        end else if (i_load) begin
            r_count <= i_loadValue;
        end else if (i_clear) begin
            r_count <= 8'd0;
        end else if (r_count != 8'd0) begin
            r_count <= r_count - 8'd1;
        end
    end

    assign o_expired = (r_count == 8'd0);

endmodule
`default_nettype wire

// File: rtl/power_manager.sv
`default_nettype none
// ============================================================================
// Module      : power_manager
// Description : Registered Moore controller in front of the Power block.
//               Maps the power switch, demand and charger presence onto
//               Power's enable/setting/mode, with throttling on warn,
//               depletion lockout with recovery hysteresis and a minimum
//               residency in ACTIVE and CHARGE.
// Ports       : clk, rst (async active-low)
//               power_on, demand[1:0], charger_present, level[7:0], warn
//               en, power_setting[1:0], power_mode, throttled, lockout,
//               shutdown_evt, state[2:0]
// Revision    : 1.0 - initial release
// ============================================================================
module power_manager
    import power_manager_pkg::*;
#(
    parameter logic [7:0] FULL_LEVEL   = c_FULL_LEVEL,
    parameter logic [7:0] RESUME_LEVEL = c_RESUME_LEVEL,
    parameter int         DWELL_CYCLES = c_DWELL_CYCLES
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       power_on,
    input  logic [1:0] demand,
    input  logic       charger_present,
    input  logic [7:0] level,
    input  logic       warn,
    output logic       en,
    output logic [1:0] power_setting,
    output logic       power_mode,
    output logic       throttled,
    output logic       lockout,
    output logic       shutdown_evt,
    output logic [2:0] state
);

    // The counter holds the cycles remaining after the current one, so a
    // residency of DWELL_CYCLES needs DWELL_CYCLES-1 loaded on entry.
    localparam logic [7:0] c_DWELL_LOAD = 8'(DWELL_CYCLES - 1);

    logic [2:0] r_state;
    logic [2:0] w_nextState;
    logic       r_lockout;
    logic       r_en;
    logic [1:0] r_setting;
    logic       r_mode;
    logic       r_throttled;
    logic       r_shutdownEvt;

    logic       w_en;
    logic [1:0] w_setting;
    logic       w_mode;
    logic       w_throttled;
    logic       w_enterDepleted;
    logic       w_dwellLoad;
    logic       w_dwellClear;
    logic       w_dwellExpired;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_nextState = c_ST_OFF;
        if (power_on) begin
            case (r_state)
                c_ST_OFF: begin
                    w_nextState = c_ST_IDLE;
                end
                c_ST_IDLE: begin
                    if (charger_present && (level < FULL_LEVEL)) begin
                        w_nextState = c_ST_CHARGE;
                    end else if ((level == 8'd0) && (demand != c_SET_OFF)) begin
                        w_nextState = c_ST_DEPLETED;
                    end else if ((demand != c_SET_OFF) && !r_lockout) begin
                        w_nextState = warn ? c_ST_THROTTLE : c_ST_ACTIVE;
                    end else begin
                        w_nextState = c_ST_IDLE;
                    end
                end
                c_ST_ACTIVE: begin
                    if (level == 8'd0) begin
                        w_nextState = c_ST_DEPLETED;
                    end else if (warn) begin
                        w_nextState = c_ST_THROTTLE;
                    end else if (demand == c_SET_OFF) begin
                        w_nextState = c_ST_IDLE;
                    end else if (charger_present && w_dwellExpired) begin
                        w_nextState = c_ST_CHARGE;
                    end else begin
                        w_nextState = c_ST_ACTIVE;
                    end
                end
                c_ST_THROTTLE: begin
                    if (level == 8'd0) begin
                        w_nextState = c_ST_DEPLETED;
                    end else if (charger_present) begin
                        w_nextState = c_ST_CHARGE;
                    end else if (demand == c_SET_OFF) begin
                        w_nextState = c_ST_IDLE;
                    end else if (!warn) begin
                        w_nextState = c_ST_ACTIVE;
                    end else begin
                        w_nextState = c_ST_THROTTLE;
                    end
                end
                c_ST_CHARGE: begin
                    // A full battery ends charging regardless of residency
                    if (level >= FULL_LEVEL) begin
                        w_nextState = c_ST_IDLE;
                    end else if (!charger_present && w_dwellExpired) begin
                        w_nextState = (level != 8'd0) ? c_ST_IDLE : c_ST_DEPLETED;
                    end else begin
                        w_nextState = c_ST_CHARGE;
                    end
                end
                c_ST_DEPLETED: begin
                    w_nextState = charger_present ? c_ST_CHARGE : c_ST_DEPLETED;
                end
                default: begin
                    w_nextState = c_ST_OFF;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output decode from the next state so outputs change on the same
    // edge as the transition.
    // ------------------------------------------------------------------
    always_comb begin
        w_en        = 1'b0;
        w_setting   = c_SET_OFF;
        w_mode      = c_MODE_RECHARGE;
        w_throttled = 1'b0;
        case (w_nextState)
            c_ST_IDLE: begin
                w_en   = 1'b1;
                w_mode = c_MODE_USE;
            end
            c_ST_ACTIVE: begin
                w_en      = 1'b1;
                w_setting = demand;
                w_mode    = c_MODE_USE;
            end
            c_ST_THROTTLE: begin
                w_en        = 1'b1;
                w_setting   = (demand > c_SET_LOW) ? c_SET_LOW : demand;
                w_mode      = c_MODE_USE;
                w_throttled = (demand > c_SET_LOW);
            end
            c_ST_CHARGE: begin
                w_en      = 1'b1;
                w_setting = c_SET_LOW;
                w_mode    = c_MODE_RECHARGE;
            end
            c_ST_DEPLETED: begin
                w_en   = 1'b1;
                w_mode = c_MODE_USE;
            end
            default: begin
                w_en = 1'b0;
            end
        endcase
    end

    assign w_enterDepleted = (w_nextState == c_ST_DEPLETED) && (r_state != c_ST_DEPLETED);

    // Load only on entry so the count runs down across the residency
    assign w_dwellLoad  = isDwellState(w_nextState) && (w_nextState != r_state);
    assign w_dwellClear = !isDwellState(w_nextState);

    dwell_timer u_dwellTimer (
        .clk         (clk),
        .rst         (rst),
        .i_load      (w_dwellLoad),
        .i_loadValue (c_DWELL_LOAD),
        .i_clear     (w_dwellClear),
        .o_expired   (w_dwellExpired)
    );

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= c_ST_OFF;
            r_lockout     <= 1'b0;
            r_en          <= 1'b0;
            r_setting     <= c_SET_OFF;
            r_mode        <= c_MODE_RECHARGE;
            r_throttled   <= 1'b0;
            r_shutdownEvt <= 1'b0;
        end else begin
            r_state       <= w_nextState;
            r_en          <= w_en;
            r_setting     <= w_setting;
            r_mode        <= w_mode;
            r_throttled   <= w_throttled;
            r_shutdownEvt <= w_enterDepleted;
            // A new depletion outranks a recovery seen on the same edge
            if (w_enterDepleted) begin
                r_lockout <= 1'b1;
            end else if (level >= RESUME_LEVEL) begin
                r_lockout <= 1'b0;
            end
        end
    end

    assign en            = r_en;
    assign power_setting = r_setting;
    assign power_mode    = r_mode;
    assign throttled     = r_throttled;
    assign lockout       = r_lockout;
    assign shutdown_evt  = r_shutdownEvt;
    assign state         = r_state;

endmodule
`default_nettype wire

// File: tb/tb_power_manager.sv
`default_nettype none
// ============================================================================
// Module      : tb_power_manager
// Description : Self-checking bench for power_manager. A behavioural model
//               tracks state residency in cycles and applies the transition
//               rules directly; every cycle the DUT outputs are compared with
//               it. A directed walk with literal expectations precedes a long
//               randomized run with occasional asynchronous resets.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_power_manager;

    localparam int FULL          = 179;
    localparam int RESUME        = 90;
    localparam int DWELL         = 4;
    localparam int RANDOM_CYCLES = 4000;

    // State numbering used by the model: 0 OFF, 1 IDLE, 2 ACTIVE,
    // 3 THROTTLE, 4 CHARGE, 5 DEPLETED.
    logic       clk             = 1'b0;
    logic       rst             = 1'b1;
    logic       power_on        = 1'b0;
    logic [1:0] demand          = 2'd0;
    logic       charger_present = 1'b0;
    logic [7:0] level           = 8'd0;
    logic       warn            = 1'b0;

    logic       en;
    logic [1:0] power_setting;
    logic       power_mode;
    logic       throttled;
    logic       lockout;
    logic       shutdown_evt;
    logic [2:0] state;

    power_manager #(
        .FULL_LEVEL   (8'(FULL)),
        .RESUME_LEVEL (8'(RESUME)),
        .DWELL_CYCLES (DWELL)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .power_on        (power_on),
        .demand          (demand),
        .charger_present (charger_present),
        .level           (level),
        .warn            (warn),
        .en              (en),
        .power_setting   (power_setting),
        .power_mode      (power_mode),
        .throttled       (throttled),
        .lockout         (lockout),
        .shutdown_evt    (shutdown_evt),
        .state           (state)
    );

    always #5 clk = ~clk;

    int checks    = 0;
    int errors    = 0;
    bit compareOn = 1'b0;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at time %0t", name, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model
    // ------------------------------------------------------------------
    int mState = 0;   // current state
    int mResid = 0;   // cycles spent in current state, 1 on the entry cycle
    bit mLock  = 1'b0;
    bit mEvt   = 1'b0;
    int mSet   = 0;
    bit mThr   = 1'b0;

    function automatic int nextOf(int s, int resid, bit lock, bit pOn, int d,
                                  bit chg, int lv, bit w);
        bit expired;
        expired = (resid >= DWELL);
        if (!pOn) return 0;
        case (s)
            0: return 1;
            1: begin
                if (chg && lv < FULL) return 4;
                if (lv == 0 && d != 0) return 5;
                if (d != 0 && !lock) return w ? 3 : 2;
                return 1;
            end
            2: begin
                if (lv == 0) return 5;
                if (w) return 3;
                if (d == 0) return 1;
                if (chg && expired) return 4;
                return 2;
            end
            3: begin
                if (lv == 0) return 5;
                if (chg) return 4;
                if (d == 0) return 1;
                if (!w) return 2;
                return 3;
            end
            4: begin
                if (lv >= FULL) return 1;
                if (!chg && expired) return (lv > 0) ? 1 : 5;
                return 4;
            end
            5: return chg ? 4 : 5;
            default: return 0;
        endcase
    endfunction

    function automatic int settingFor(int s, int d);
        case (s)
            2:       return d;
            3:       return (d > 1) ? 1 : d;
            4:       return 1;
            default: return 0;
        endcase
    endfunction

    function automatic int modelNext();
        return nextOf(mState, mResid, mLock, power_on, int'(demand),
                      charger_present, int'(level), warn);
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mState <= 0;
            mResid <= 0;
            mLock  <= 1'b0;
            mEvt   <= 1'b0;
            mSet   <= 0;
            mThr   <= 1'b0;
        end else begin
            mState <= modelNext();
            mResid <= (modelNext() == mState) ? ((mResid < 1000) ? mResid + 1 : mResid) : 1;
            mEvt   <= (modelNext() == 5) && (mState != 5);
            mLock  <= ((modelNext() == 5) && (mState != 5)) ? 1'b1
                    : ((int'(level) >= RESUME) ? 1'b0 : mLock);
            mSet   <= settingFor(modelNext(), int'(demand));
            mThr   <= (modelNext() == 3) && (demand > 2'd1);
        end
    end

    // ------------------------------------------------------------------
    // Per-cycle comparison against the model, away from the active edge
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        if (compareOn) begin
            chk("state",        int'(state),         mState);
            chk("en",           int'(en),            (mState != 0) ? 1 : 0);
            chk("setting",      int'(power_setting), mSet);
            chk("mode",         int'(power_mode),    (mState == 0 || mState == 4) ? 0 : 1);
            chk("throttled",    int'(throttled),     int'(mThr));
            chk("lockout",      int'(lockout),       int'(mLock));
            chk("shutdown_evt", int'(shutdown_evt),  int'(mEvt));
        end
    end

    task automatic allZero(input string tag);
        chk({tag, "_state"},   int'(state),         0);
        chk({tag, "_en"},      int'(en),            0);
        chk({tag, "_setting"}, int'(power_setting), 0);
        chk({tag, "_mode"},    int'(power_mode),    0);
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        // Asynchronous reset before any clock edge
        #2 rst = 1'b0;
        #1;
        allZero("reset");
        chk("reset_lockout", int'(lockout), 0);
        chk("reset_shutdown", int'(shutdown_evt), 0);
        compareOn = 1'b1;
        @(negedge clk);
        @(negedge clk);

        // Power up into ACTIVE
        rst = 1'b1; power_on = 1'b1; demand = 2'd3; level = 8'd120; warn = 1'b0;
        @(negedge clk); chk("up_idle", int'(state), 1);
        @(negedge clk); chk("up_active", int'(state), 2);
        chk("up_setting", int'(power_setting), 3);
        chk("up_mode", int'(power_mode), 1);
        chk("up_en", int'(en), 1);

        // Warn throttles, release returns to ACTIVE
        warn = 1'b1; level = 8'd44;
        @(negedge clk); chk("thr_state", int'(state), 3);
        chk("thr_setting", int'(power_setting), 1);
        chk("thr_flag", int'(throttled), 1);
        warn = 1'b0;
        @(negedge clk); chk("unthr_state", int'(state), 2);
        chk("unthr_setting", int'(power_setting), 3);

        // Depletion from THROTTLE
        warn = 1'b1; level = 8'd2;
        @(negedge clk); chk("pre_dep_state", int'(state), 3);
        level = 8'd0;
        @(negedge clk); chk("dep_state", int'(state), 5);
        chk("dep_evt", int'(shutdown_evt), 1);
        chk("dep_lock", int'(lockout), 1);
        @(negedge clk); chk("dep_hold_state", int'(state), 5);
        chk("dep_evt_once", int'(shutdown_evt), 0);

        // Recharge and lockout hysteresis
        charger_present = 1'b1; warn = 1'b0;
        @(negedge clk); chk("chg_state", int'(state), 4);
        chk("chg_mode", int'(power_mode), 0);
        chk("chg_setting", int'(power_setting), 1);
        level = 8'd89;
        @(negedge clk); chk("lock_89", int'(lockout), 1);
        level = 8'd90;
        @(negedge clk); chk("lock_90", int'(lockout), 0);
        level = 8'd179;
        @(negedge clk); chk("full_idle", int'(state), 1);
        charger_present = 1'b0; level = 8'd120;
        @(negedge clk); chk("resume_active", int'(state), 2);

        // ACTIVE residency with charger present from the entry cycle
        charger_present = 1'b1;
        repeat (3) @(negedge clk);
        chk("dwell_active_c4", int'(state), 2);
        @(negedge clk); chk("dwell_to_charge", int'(state), 4);

        // CHARGE residency after the charger is removed
        charger_present = 1'b0;
        repeat (3) @(negedge clk);
        chk("dwell_charge_c4", int'(state), 4);
        @(negedge clk); chk("dwell_to_idle", int'(state), 1);

        // Switch-off overrides unexpired dwell
        charger_present = 1'b1;
        @(negedge clk); chk("chg_again", int'(state), 4);
        power_on = 1'b0;
        @(negedge clk); allZero("pwroff");

        // Mid-cycle asynchronous reset from ACTIVE
        power_on = 1'b1; charger_present = 1'b0; demand = 2'd2;
        @(negedge clk); chk("re_idle", int'(state), 1);
        @(negedge clk); chk("re_active", int'(state), 2);
        chk("re_setting", int'(power_setting), 2);
        @(posedge clk);
        #3 rst = 1'b0;
        #1 allZero("async_rst");
        @(negedge clk);
        rst = 1'b1;

        // Randomized run
        for (int cyc = 0; cyc < RANDOM_CYCLES; cyc++) begin
            int lv;
            int r;
            int t;
            power_on = ($urandom_range(0, 99) < 97);
            if ($urandom_range(0, 4) == 0) demand = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) charger_present = ~charger_present;
            lv = int'(level);
            r  = $urandom_range(0, 99);
            if (r < 4) begin
                lv = 0;
            end else if (r < 10) begin
                case ($urandom_range(0, 4))
                    0:       lv = 89;
                    1:       lv = 90;
                    2:       lv = 178;
                    3:       lv = 179;
                    default: lv = 1;
                endcase
            end else if (r < 60) begin
                t  = int'($urandom_range(0, 12));
                lv = lv + t - 6;
                if (lv < 0) lv = 0;
                if (lv > 255) lv = 255;
            end
            level = 8'(lv);
            warn  = (lv < 45);
            if ($urandom_range(0, 9) == 0) warn = ~warn;

            if ($urandom_range(0, 299) == 0) begin
                @(posedge clk);
                #3 rst = 1'b0;
                #1 allZero("rand_rst");
                @(negedge clk);
                rst = 1'b1;
            end else begin
                @(negedge clk);
            end
        end

        compareOn = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
